bus_rr_matrix: RTL

Parametrised shared-bus interconnect with NUM_M masters and NUM_S slaves. It is the next-generation system bus between the CPU/DMA masters and the memory/peripheral slaves. It adds round-robin arbitration with grant parking, a hold-limit counter that bounds how long one master can keep the bus, decoded slave select qualified by request, and a registered read-return path with an unmapped-address error flag.

---
 rtl/bus_rr_pkg.sv | 24 ++
 rtl/bus_rr_arbiter.sv | 70 +++++++
 rtl/bus_rr_matrix.sv | 82 ++++++++
 3 files changed

// File: rtl/bus_rr_pkg.sv
// Shared constants and helpers for the round-robin bus matrix.
package bus_rr_pkg;

   localparam int unsigned DEF_NUM_M    = 2;
   localparam int unsigned DEF_NUM_S    = 5;
   localparam int unsigned DEF_ADDR_W   = 8;
   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_SEL_W    = 3;
   localparam int unsigned DEF_MAX_HOLD = 8;

   // Read data returned when no slave was selected on the previous cycle.
   localparam int unsigned UNMAPPED_DATA = 0;

   // Index of the set bit in a one-hot vector (up to 32 entries); 0 for an all-zero input.
   function automatic logic [4:0] onehot_to_idx(input logic [31:0] i_oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (i_oh[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter with grant parking and a hold limit under contention.
module bus_rr_arbiter
   import bus_rr_pkg::*;
#(
   parameter int unsigned NUM_M    = DEF_NUM_M,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_M-1:0]           i_req,
   output logic [NUM_M-1:0]           o_grant,
   output logic [$clog2(NUM_M)-1:0]   o_owner
);

   localparam int unsigned IDX_W  = $clog2(NUM_M);
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [IDX_W:0]    NUM_M_W   = (IDX_W + 1)'(NUM_M);

   logic [NUM_M-1:0]  r_grant;
   logic [HOLD_W-1:0] r_hold;
   logic [IDX_W-1:0]  w_owner;
   logic              w_owner_req;
   logic              w_others;
   logic              w_switch;
   logic [NUM_M-1:0]  w_next_grant;
   logic [IDX_W:0]    w_cand;
   logic              w_found;

   assign w_owner     = IDX_W'(onehot_to_idx(32'(r_grant)));
   assign w_owner_req = i_req[w_owner];
   assign w_others    = |(i_req & ~r_grant);
   // Give up the bus when idle-owner with waiters, or when the hold limit is hit under contention.
   assign w_switch    = w_others & (~w_owner_req | (r_hold == HOLD_LAST));

   // First requester after the owner, wrapping modulo NUM_M.
   always_comb begin
      w_next_grant = r_grant;
      w_found      = 1'b0;
      w_cand       = '0;
      for (int k = 1; k < NUM_M; k++) begin
         w_cand = {1'b0, w_owner} + (IDX_W + 1)'(k);
         if (w_cand >= NUM_M_W) w_cand = w_cand - NUM_M_W;
         if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
            w_next_grant                      = '0;
            w_next_grant[w_cand[IDX_W-1:0]]   = 1'b1;
            w_found                           = 1'b1;
         end
      end
   end

   // Grant register and hold counter; counter saturates while the owner keeps requesting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grant <= NUM_M'(1);
         r_hold  <= '0;
      end else if (w_switch) begin
         r_grant <= w_next_grant;
         r_hold  <= '0;
      end else if (w_owner_req) begin
         if (r_hold != HOLD_LAST) r_hold <= r_hold + 1'b1;
      end else begin
         r_hold <= '0;
      end
   end

   assign o_grant = r_grant;
   assign o_owner = w_owner;

endmodule

// File: rtl/bus_rr_matrix.sv
// Shared-bus interconnect: arbiter, owner muxes, slave decode and registered read return.
module bus_rr_matrix
   import bus_rr_pkg::*;
#(
   parameter int unsigned NUM_M    = DEF_NUM_M,
   parameter int unsigned NUM_S    = DEF_NUM_S,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned SEL_W    = DEF_SEL_W,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_M-1:0]          m_req,
   input  logic [NUM_M-1:0]          m_wr,
   input  logic [NUM_M*ADDR_W-1:0]   m_address,
   input  logic [NUM_M*DATA_W-1:0]   m_dout,
   output logic [NUM_M-1:0]          m_grant,
   output logic [DATA_W-1:0]         m_din,
   output logic                      m_err,
   input  logic [NUM_S*DATA_W-1:0]   s_dout,
   output logic [NUM_S-1:0]          s_sel,
   output logic [ADDR_W-1:0]         s_address,
   output logic                      s_wr,
   output logic [DATA_W-1:0]         s_din
);

   localparam int unsigned IDX_W = $clog2(NUM_M);
   localparam logic [SEL_W:0] NUM_S_W = (SEL_W + 1)'(NUM_S);

   logic [IDX_W-1:0] w_owner;
   logic             w_owner_req;
   logic [SEL_W-1:0] w_idx;
   logic             w_mapped;
   logic [NUM_S-1:0] r_rd_sel;
   logic             r_err;
   logic [4:0]       w_rd_idx;

   bus_rr_arbiter #(
      .NUM_M    (NUM_M),
      .MAX_HOLD (MAX_HOLD)
   ) u_arbiter (
      .clk     (clk),
      .reset   (reset),
      .i_req   (m_req),
      .o_grant (m_grant),
      .o_owner (w_owner)
   );

   assign w_owner_req = m_req[w_owner];
   assign s_address   = m_address[w_owner*ADDR_W +: ADDR_W];
   assign s_din       = m_dout[w_owner*DATA_W +: DATA_W];
   assign s_wr        = m_wr[w_owner] & w_owner_req;

   assign w_idx    = s_address[ADDR_W-1 -: SEL_W];
   assign w_mapped = ({1'b0, w_idx} < NUM_S_W);

   // One-hot slave select, qualified by the owner's request and forced off during reset.
   always_comb begin
      s_sel = '0;
      for (int s = 0; s < NUM_S; s++) begin
         if (!reset && w_mapped && (w_idx == SEL_W'(s))) s_sel[s] = w_owner_req;
      end
   end

   // Read-return registers: remember which slave answers next cycle, and flag unmapped accesses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_sel <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rd_sel <= s_sel;
         r_err    <= w_owner_req & ~w_mapped;
      end
   end

   assign w_rd_idx = onehot_to_idx(32'(r_rd_sel));
   assign m_din    = (r_rd_sel == '0) ? DATA_W'(UNMAPPED_DATA)
                                      : s_dout[w_rd_idx*DATA_W +: DATA_W];
   assign m_err    = r_err;

endmodule
